// File: rtl/pe_pkg.sv
// Shared types and instruction field layout for the PE operand issue stage.
package pe_pkg;

  localparam int unsigned SEL_W     = 3;
  localparam int unsigned FUNCT_W   = 3;
  localparam int unsigned CONST_W   = 8;

  localparam int unsigned FUNCT_LSB = 12;
  localparam int unsigned SRC1_LSB  = 15;
  localparam int unsigned SRC2_LSB  = 18;
  localparam int unsigned CONST_LSB = 24;

  localparam logic [SEL_W-1:0] SRC_N     = 3'd0;
  localparam logic [SEL_W-1:0] SRC_E     = 3'd1;
  localparam logic [SEL_W-1:0] SRC_S     = 3'd2;
  localparam logic [SEL_W-1:0] SRC_W     = 3'd3;
  localparam logic [SEL_W-1:0] SRC_FB    = 3'd4;
  localparam logic [SEL_W-1:0] SRC_CONST = 3'd5;

  localparam logic [FUNCT_W-1:0] ALU_ADD = 3'b000;
  localparam logic [FUNCT_W-1:0] ALU_SUB = 3'b001;
  localparam logic [FUNCT_W-1:0] ALU_AND = 3'b010;
  localparam logic [FUNCT_W-1:0] ALU_OR  = 3'b011;
  localparam logic [FUNCT_W-1:0] ALU_XOR = 3'b100;
  localparam logic [FUNCT_W-1:0] ALU_SHL = 3'b101;
  localparam logic [FUNCT_W-1:0] ALU_SHR = 3'b110;
  localparam logic [FUNCT_W-1:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_EXEC,
    S_HOLD
  } state_t;

endpackage

// File: rtl/pe_src_mux.sv
// Operand source select: neighbour channel, feedback register or zero-extended constant.
module pe_src_mux
  import pe_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NNBR = 4
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic [NNBR*DW-1:0]  nbr_data,
  input  logic [DW-1:0]       fb,
  input  logic [CONST_W-1:0]  cnst,
  output logic [DW-1:0]       data,
  output logic                is_nbr,
  output logic [1:0]          chan
);

  assign is_nbr = (sel <= SRC_W);
  assign chan   = sel[1:0];

  always_comb begin
    data = '0;
    case (sel)
      SRC_N, SRC_E, SRC_S, SRC_W: data = nbr_data[32'(sel[1:0]) * DW +: DW];
      SRC_FB:                     data = fb;
      SRC_CONST:                  data = DW'(cnst);
      default:                    data = '0;
    endcase
  end

endmodule

// File: rtl/pe_operand_issue.sv
// Issue/writeback stage around the tile ALU: gathers two operands, fires the ALU for one
// cycle, holds the result on a valid/ready channel, then repeats until cleared.
module pe_operand_issue
  import pe_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NNBR = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_instr,
  input  logic                cfg_clear,
  input  logic [NNBR*DW-1:0]  nbr_data,
  input  logic [NNBR-1:0]     nbr_valid,
  output logic [NNBR-1:0]     nbr_ready,
  output logic [DW-1:0]       alu_in1,
  output logic [DW-1:0]       alu_in2,
  output logic                alu_en,
  output logic [2:0]          alu_instruction,
  input  logic [DW-1:0]       alu_result,
  output logic [DW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  state_t               state;
  logic [FUNCT_W-1:0]   funct;
  logic [SEL_W-1:0]     src1, src2;
  logic [CONST_W-1:0]   cnst;
  logic [DW-1:0]        op1, op2, fb;
  logic                 got1, got2;

  logic [DW-1:0]        d1, d2;
  logic                 n1, n2;
  logic [1:0]           c1, c2;
  logic                 fill1, fill2, done;
  logic                 unused_instr_bits;

  assign unused_instr_bits = ^{cfg_instr[FUNCT_LSB-1:0], cfg_instr[CONST_LSB-1:SRC2_LSB+SEL_W]};

  pe_src_mux #(.DW(DW), .NNBR(NNBR)) u_src1 (
    .sel(src1), .nbr_data(nbr_data), .fb(fb), .cnst(cnst),
    .data(d1), .is_nbr(n1), .chan(c1)
  );

  pe_src_mux #(.DW(DW), .NNBR(NNBR)) u_src2 (
    .sel(src2), .nbr_data(nbr_data), .fb(fb), .cnst(cnst),
    .data(d2), .is_nbr(n2), .chan(c2)
  );

  assign cfg_ready = (state == S_IDLE);

  // Ready depends only on state, fill flags and selects so it never loops back on valid.
  always_comb begin
    nbr_ready = '0;
    if (state == S_GATHER) begin
      if (!got1 && n1) nbr_ready[c1] = 1'b1;
      if (!got2 && n2) nbr_ready[c2] = 1'b1;
    end
  end

  // A shared channel raises one ready bit, so a single beat satisfies both operands.
  assign fill1 = (state == S_GATHER) && !got1 && (!n1 || nbr_valid[c1]);
  assign fill2 = (state == S_GATHER) && !got2 && (!n2 || nbr_valid[c2]);
  assign done  = (got1 || fill1) && (got2 || fill2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      funct           <= '0;
      src1            <= '0;
      src2            <= '0;
      cnst            <= '0;
      op1             <= '0;
      op2             <= '0;
      fb              <= '0;
      got1            <= 1'b0;
      got2            <= 1'b0;
      alu_en          <= 1'b0;
      alu_in1         <= '0;
      alu_in2         <= '0;
      alu_instruction <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
    end else if (cfg_clear) begin
      state     <= S_IDLE;
      got1      <= 1'b0;
      got2      <= 1'b0;
      alu_en    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            funct <= cfg_instr[FUNCT_LSB +: FUNCT_W];
            src1  <= cfg_instr[SRC1_LSB +: SEL_W];
            src2  <= cfg_instr[SRC2_LSB +: SEL_W];
            cnst  <= cfg_instr[CONST_LSB +: CONST_W];
            got1  <= 1'b0;
            got2  <= 1'b0;
            state <= S_GATHER;
          end
        end
        S_GATHER: begin
          if (fill1) begin
            op1  <= d1;
            got1 <= 1'b1;
          end
          if (fill2) begin
            op2  <= d2;
            got2 <= 1'b1;
          end
          if (done) begin
            alu_en          <= 1'b1;
            alu_in1         <= fill1 ? d1 : op1;
            alu_in2         <= fill2 ? d2 : op2;
            alu_instruction <= funct;
            state           <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_en    <= 1'b0;
          out_data  <= alu_result;
          fb        <= alu_result;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            got1      <= 1'b0;
            got2      <= 1'b0;
            state     <= S_GATHER;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_issue.sv
// Directed bench for pe_operand_issue with a scoreboard queue of expected results.
module tb_pe_operand_issue;

  localparam int unsigned DW   = 32;
  localparam int unsigned NNBR = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_valid, cfg_ready, cfg_clear;
  logic [31:0]         cfg_instr;
  logic [NNBR*DW-1:0]  nbr_data;
  logic [NNBR-1:0]     nbr_valid, nbr_ready;
  logic [DW-1:0]       alu_in1, alu_in2, alu_result, out_data;
  logic                alu_en, out_valid, out_ready;
  logic [2:0]          alu_instruction;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0;
  int beats [NNBR];
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int en0, b0, w0;
  logic [31:0] fb_model;
  logic [31:0] exp_q [$];

  pe_operand_issue #(.DW(DW), .NNBR(NNBR)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_instr(cfg_instr), .cfg_clear(cfg_clear),
    .nbr_data(nbr_data), .nbr_valid(nbr_valid), .nbr_ready(nbr_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_en(alu_en), .alu_instruction(alu_instruction),
    .alu_result(alu_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Stand-in for the tile ALU that sits outside this block.
  always_comb begin
    case (alu_instruction)
      3'b000:  alu_result = alu_in1 + alu_in2;
      3'b001:  alu_result = alu_in1 - alu_in2;
      3'b010:  alu_result = alu_in1 & alu_in2;
      3'b011:  alu_result = alu_in1 | alu_in2;
      3'b100:  alu_result = alu_in1 ^ alu_in2;
      3'b101:  alu_result = alu_in1 << alu_in2[4:0];
      3'b110:  alu_result = alu_in1 >> alu_in2[4:0];
      default: alu_result = {31'b0, alu_in1 == alu_in2};
    endcase
  end

  initial for (int k = 0; k < NNBR; k++) beats[k] = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_en) en_cnt <= en_cnt + 1;
    for (int k = 0; k < NNBR; k++)
      if (nbr_valid[k] && nbr_ready[k]) beats[k] <= beats[k] + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [2:0] f, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [7:0] c);
    logic [31:0] r;
    r = '0;
    r[14:12] = f;
    r[17:15] = s1;
    r[20:18] = s2;
    r[31:24] = c;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_nbr(input int k, input logic [31:0] v, input logic vld);
    nbr_data[k*DW +: DW] = v;
    nbr_valid[k]         = vld;
  endtask

  task automatic load(input logic [31:0] instr);
    cfg_valid = 1'b1;
    cfg_instr = instr;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check(tag, out_data, e);
    prev_vcyc = last_vcyc;
    last_vcyc = cyc;
  endtask

  function automatic int beat_sum();
    int s;
    s = 0;
    for (int k = 0; k < NNBR; k++) s += beats[k];
    return s;
  endfunction

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_instr = '0; cfg_clear = 1'b0;
    nbr_data = '0; nbr_valid = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("rst_nbr_ready", {28'b0, nbr_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_en",    {31'b0, alu_en}, 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Shared W channel feeds both operands from one beat; 9 - 9 = 0.
    out_ready = 1'b1;
    load(mk(3'b001, 3'd3, 3'd3, 8'h00));
    check("w_ready", {28'b0, nbr_ready}, 32'h8);
    w0 = beats[3];
    set_nbr(3, 32'd9, 1'b1);
    exp_q.push_back(32'd0);
    @(negedge clk);
    check("w_alu_en", {31'b0, alu_en}, 32'd1);
    check("w_in1", alu_in1, 32'd9);
    check("w_in2", alu_in2, 32'd9);
    check("w_func", {29'b0, alu_instruction}, 32'd1);
    @(negedge clk);
    check("w_ready_off", {28'b0, nbr_ready}, 32'd0);
    expect_out("w_out");
    nbr_valid = '0;
    check("w_beats", 32'(beats[3] - w0), 32'd1);
    @(negedge clk);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    check("w_clr_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // Clear while idle wins over an offered instruction.
    cfg_clear = 1'b1; cfg_valid = 1'b1; cfg_instr = mk(3'b000, 3'd0, 3'd1, 8'h00);
    @(negedge clk);
    cfg_clear = 1'b0; cfg_valid = 1'b0;
    check("idle_clr_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("idle_clr_nbr_ready", {28'b0, nbr_ready}, 32'd0);

    // N then E arrive on separate cycles; 5 + 7 = 12, then backpressure.
    out_ready = 1'b0;
    load(mk(3'b000, 3'd0, 3'd1, 8'h00));
    check("ne_ready", {28'b0, nbr_ready}, 32'h3);
    @(negedge clk);
    set_nbr(0, 32'd5, 1'b1);
    @(negedge clk);
    nbr_valid[0] = 1'b0;
    check("ne_n_dropped", {28'b0, nbr_ready}, 32'h2);
    check("ne_no_en_yet", {31'b0, alu_en}, 32'd0);
    repeat (2) @(negedge clk);
    set_nbr(1, 32'd7, 1'b1);
    exp_q.push_back(32'd12);
    @(negedge clk);
    nbr_valid[1] = 1'b0;
    check("ne_alu_en", {31'b0, alu_en}, 32'd1);
    check("ne_in1", alu_in1, 32'd5);
    check("ne_in2", alu_in2, 32'd7);
    expect_out("ne_out");
    en0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'd12);
      check("bp_nbr_ready", {28'b0, nbr_ready}, 32'd0);
    end
    check("bp_no_second_en", 32'(en_cnt - en0), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_valid_low", {31'b0, out_valid}, 32'd0);
    check("stream_regather", {28'b0, nbr_ready}, 32'h3);

    // Clear during gather: nothing is consumed afterwards.
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    check("gclr_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("gclr_nbr_ready", {28'b0, nbr_ready}, 32'd0);
    check("gclr_out_valid", {31'b0, out_valid}, 32'd0);
    b0 = beat_sum();
    nbr_valid = '1;
    repeat (3) @(negedge clk);
    nbr_valid = '0;
    check("gclr_no_beats", 32'(beat_sum() - b0), 32'd0);

    // Feedback + constant streaming from fb = 12: 15, 18, 21, three cycles apart.
    fb_model = 32'd12;
    load(mk(3'b000, 3'd4, 3'd5, 8'h03));
    for (int i = 0; i < 3; i++) begin
      fb_model = fb_model + 32'd3;
      exp_q.push_back(fb_model);
    end
    for (int i = 0; i < 3; i++) begin
      expect_out("fb_out");
      if (i > 0) check("fb_spacing", 32'(last_vcyc - prev_vcyc), 32'd3);
      @(negedge clk);
    end
    out_ready = 1'b0;
    fb_model = fb_model + 32'd3;
    exp_q.push_back(fb_model);
    expect_out("fb_out_hold");

    // Clear during hold discards the pending result.
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    check("hclr_out_valid", {31'b0, out_valid}, 32'd0);
    check("hclr_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("hclr_alu_en", {31'b0, alu_en}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("hclr_stays_idle", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset between edges, then a fresh instruction.
    load(mk(3'b000, 3'd1, 3'd2, 8'h00));
    check("ar_ready", {28'b0, nbr_ready}, 32'h6);
    #2 rst = 1'b1;
    #1;
    check("ar_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    check("ar_nbr_ready", {28'b0, nbr_ready}, 32'd0);
    check("ar_out_data", out_data, 32'd0);
    check("ar_alu_in1", alu_in1, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    load(mk(3'b000, 3'd1, 3'd2, 8'h00));
    set_nbr(1, 32'd100, 1'b1);
    set_nbr(2, 32'd23, 1'b1);
    exp_q.push_back(32'd123);
    @(negedge clk);
    nbr_valid = '0;
    check("ar2_in1", alu_in1, 32'd100);
    check("ar2_in2", alu_in2, 32'd23);
    expect_out("ar2_out");
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
